// File: rtl/rv_io_modport.sv
// rtl/rv_io_modport.sv - registered bidirectional I/O bank with edge flags and interrupt
//
// Purpose: WIDTH tri-state pins behind a small register port. OUT/DIR drive the
// pad ring, pad inputs are synchronized into IN, and IN transitions latch sticky
// RISE/FALL flags that raise a maskable registered interrupt.
//
// Optional feature: define RV_IO_MODPORT_DEBOUNCE_EN to insert a per-pin debouncer
// (DEBOUNCE_CYCLES stable samples) between the synchronizer and IN.
//
// Ports:
//   clk      - clock, all logic on rising edge
//   rst      - synchronous active-high reset
//   pad_i    - pin inputs (asynchronous)
//   pad_o    - pin output values (OUT register)
//   pad_t    - tri-state control, 1 = high-Z/input (DIR register)
//   wr_en    - register write strobe
//   rd_en    - register read strobe
//   addr     - register address (0 OUT, 1 DIR, 2 IN, 3 RISE, 4 FALL, 5 MASK, 6 OUT_SET, 7 OUT_CLR)
//   wdata    - write data
//   rdata    - read data, valid with rd_valid, held otherwise
//   rd_valid - read data valid, one cycle after rd_en
//   irq      - registered interrupt, |((RISE | FALL) & MASK)

module rv_io_modport #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] pad_o,
    output logic [WIDTH-1:0] pad_t,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             rd_valid,
    output logic             irq
);

    localparam logic [2:0] A_OUT     = 3'd0;
    localparam logic [2:0] A_DIR     = 3'd1;
    localparam logic [2:0] A_IN      = 3'd2;
    localparam logic [2:0] A_RISE    = 3'd3;
    localparam logic [2:0] A_FALL    = 3'd4;
    localparam logic [2:0] A_MASK    = 3'd5;
    localparam logic [2:0] A_OUT_SET = 3'd6;
    localparam logic [2:0] A_OUT_CLR = 3'd7;

    // Edge detection stays off until IN has settled on real pad data, so the
    // reset-value-to-first-sample step never produces flags. With the debouncer
    // that settling takes DEBOUNCE_CYCLES more edges.
`ifdef RV_IO_MODPORT_DEBOUNCE_EN
    localparam int ARM_CYCLES = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;
`else
    localparam int ARM_CYCLES = SYNC_STAGES + 1;
`endif
    localparam int              AW       = $clog2(ARM_CYCLES + 1);
    localparam logic [AW-1:0]   ARM_LAST = AW'(ARM_CYCLES);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] in_val;
    logic [AW-1:0]    arm_cnt;
    logic             armed;

    assign pad_o = out_q;
    assign pad_t = dir_q;
    assign armed = (arm_cnt == ARM_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pad_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef RV_IO_MODPORT_DEBOUNCE_EN
    localparam int            DW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [DW-1:0]    deb_cnt [WIDTH];
    logic [WIDTH-1:0] deb_q;

    // A bit flips only after DEBOUNCE_CYCLES consecutive samples disagree with
    // it; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_q <= '0;
            for (int b = 0; b < WIDTH; b++) deb_cnt[b] <= '0;
        end else begin
            for (int b = 0; b < WIDTH; b++) begin
                if (sync_q[SYNC_STAGES-1][b] != deb_q[b]) begin
                    if (deb_cnt[b] == DEB_LAST) begin
                        deb_q[b]   <= sync_q[SYNC_STAGES-1][b];
                        deb_cnt[b] <= '0;
                    end else begin
                        deb_cnt[b] <= deb_cnt[b] + DW'(1);
                    end
                end else begin
                    deb_cnt[b] <= '0;
                end
            end
        end
    end

    assign in_val = deb_q;
`else
    assign in_val = sync_q[SYNC_STAGES-1];
`endif

    logic [WIDTH-1:0] rise_set;
    logic [WIDTH-1:0] fall_set;
    logic [WIDTH-1:0] rise_clr;
    logic [WIDTH-1:0] fall_clr;

    always_comb begin
        rise_set = armed ? (in_val & ~prev_q) : '0;
        fall_set = armed ? (~in_val & prev_q) : '0;
        rise_clr = (wr_en && addr == A_RISE) ? wdata : '0;
        fall_clr = (wr_en && addr == A_FALL) ? wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arm_cnt <= '0;
            prev_q  <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            irq     <= 1'b0;
        end else begin
            if (!armed) arm_cnt <= arm_cnt + AW'(1);
            prev_q <= in_val;
            // Set term ORed last so a same-cycle hardware set beats the w1c.
            rise_q <= (rise_q & ~rise_clr) | rise_set;
            fall_q <= (fall_q & ~fall_clr) | fall_set;
            irq    <= |((rise_q | fall_q) & mask_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            dir_q  <= '1;
            mask_q <= '0;
        end else if (wr_en) begin
            case (addr)
                A_OUT:     out_q  <= wdata;
                A_DIR:     dir_q  <= wdata;
                A_MASK:    mask_q <= wdata;
                A_OUT_SET: out_q  <= out_q | wdata;
                A_OUT_CLR: out_q  <= out_q & ~wdata;
                default:   ;
            endcase
        end
    end

    // Reads sample pre-write register values, so a same-cycle write+read
    // returns the old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rdata    <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                case (addr)
                    A_OUT:   rdata <= out_q;
                    A_DIR:   rdata <= dir_q;
                    A_IN:    rdata <= in_val;
                    A_RISE:  rdata <= rise_q;
                    A_FALL:  rdata <= fall_q;
                    A_MASK:  rdata <= mask_q;
                    default: rdata <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rv_io_modport.sv
// tb/tb_rv_io_modport.sv - self-checking bench for rv_io_modport

module tb_rv_io_modport;

    localparam int S = 2;
`ifdef RV_IO_MODPORT_DEBOUNCE_EN
    localparam int D = 4;
`else
    localparam int D = 0;
`endif
    localparam int ARM      = S + 1 + D;
    localparam int EDGE_LAT = S + 1 + D;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pad_i = 8'h00;
    logic [7:0] pad_o;
    logic [7:0] pad_t;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [2:0] addr = 3'd0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       rd_valid;
    logic       irq;

    int vecs = 0;
    int errs = 0;

    rv_io_modport #(
        .WIDTH(8),
        .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES((D == 0) ? 16 : D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pad_i(pad_i),
        .pad_o(pad_o),
        .pad_t(pad_t),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .rd_valid(rd_valid),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: register file semantics plus IN expressed as a delayed
    // (and, if built, windowed) view of the sampled pad history.
    logic [7:0] m_out, m_dir, m_mask, m_rise, m_fall, m_rdata, m_in, m_in1;
    logic       m_irq, m_rv;
    logic [7:0] samples[$];
    logic [7:0] sq[$];
    int         m_e;

    always @(posedge clk) begin : model
        logic [7:0] setr, setf, s_now, new_in;
        bit         all_diff;
        if (rst) begin
            m_out = 0; m_dir = 8'hFF; m_mask = 0; m_rise = 0; m_fall = 0;
            m_rdata = 0; m_in = 0; m_in1 = 0; m_irq = 0; m_rv = 0;
            samples.delete(); sq.delete(); m_e = 0;
        end else begin
            if (rd_en) begin
                case (addr)
                    3'd0: m_rdata = m_out;
                    3'd1: m_rdata = m_dir;
                    3'd2: m_rdata = m_in;
                    3'd3: m_rdata = m_rise;
                    3'd4: m_rdata = m_fall;
                    3'd5: m_rdata = m_mask;
                    default: m_rdata = 8'h00;
                endcase
            end
            m_rv  = rd_en;
            m_irq = |((m_rise | m_fall) & m_mask);
            m_e++;
            setr = (m_e >= ARM + 1) ? (m_in & ~m_in1) : 8'h00;
            setf = (m_e >= ARM + 1) ? (~m_in & m_in1) : 8'h00;
            if (wr_en) begin
                case (addr)
                    3'd0: m_out = wdata;
                    3'd1: m_dir = wdata;
                    3'd3: m_rise = m_rise & ~wdata;
                    3'd4: m_fall = m_fall & ~wdata;
                    3'd5: m_mask = wdata;
                    3'd6: m_out = m_out | wdata;
                    3'd7: m_out = m_out & ~wdata;
                    default: ;
                endcase
            end
            m_rise = m_rise | setr;
            m_fall = m_fall | setf;
            samples.push_back(pad_i);
            s_now = (m_e >= S) ? samples[m_e - S] : 8'h00;
            new_in = m_in;
            if (D == 0) begin
                new_in = s_now;
            end else if (sq.size() >= D) begin
                for (int b = 0; b < 8; b++) begin
                    all_diff = 1;
                    for (int k = 0; k < D; k++)
                        if (sq[sq.size() - 1 - k][b] == m_in[b]) all_diff = 0;
                    if (all_diff) new_in[b] = ~m_in[b];
                end
            end
            sq.push_back(s_now);
            m_in1 = m_in;
            m_in  = new_in;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        tick();
    endtask

    task automatic rd(input logic [2:0] a);
        rd_en = 1'b1; addr = a;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; pad_i = 8'hFF;
        idle(3);
        vecs++; if (pad_t !== 8'hFF) begin errs++; $display("FAIL reset_pad_t got %h exp ff", pad_t); end
        vecs++; if (pad_o !== 8'h00) begin errs++; $display("FAIL reset_pad_o got %h exp 00", pad_o); end
        vecs++; if (irq !== 1'b0) begin errs++; $display("FAIL reset_irq got %b exp 0", irq); end
        vecs++; if (rd_valid !== 1'b0) begin errs++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
        vecs++; if (rdata !== 8'h00) begin errs++; $display("FAIL reset_rdata got %h exp 00", rdata); end
        rst = 1'b0;
        idle(12);
        rd(3'd2);
        vecs++; if (rd_valid !== 1'b1 || rdata !== 8'hFF) begin errs++; $display("FAIL reset_in got v=%b %h exp v=1 ff", rd_valid, rdata); end
        rd(3'd3);
        vecs++; if (rdata !== 8'h00) begin errs++; $display("FAIL reset_rise got %h exp 00", rdata); end
        vecs++; if (irq !== 1'b0) begin errs++; $display("FAIL reset_irq_after got %b exp 0", irq); end
    endtask

    task automatic test_registers();
        logic [7:0] exp_rd [4] = '{8'h27, 8'h0F, 8'h00, 8'h00};
        logic [2:0] rd_a [4] = '{3'd0, 3'd1, 3'd6, 3'd7};
        wr(3'd0, 8'hA5);
        wr(3'd1, 8'h0F);
        wr(3'd6, 8'h02);
        wr(3'd7, 8'h80);
        vecs++; if (pad_o !== 8'h27) begin errs++; $display("FAIL regs_pad_o got %h exp 27", pad_o); end
        vecs++; if (pad_t !== 8'h0F) begin errs++; $display("FAIL regs_pad_t got %h exp 0f", pad_t); end
        for (int i = 0; i < 4; i++) begin
            rd(rd_a[i]);
            vecs++; if (rdata !== exp_rd[i]) begin errs++; $display("FAIL regs_read a=%0d got %h exp %h", rd_a[i], rdata, exp_rd[i]); end
        end
        wr(3'd2, 8'h00);
        wr(3'd5, 8'h5A);
        rd(3'd5);
        vecs++; if (rdata !== 8'h5A) begin errs++; $display("FAIL regs_mask got %h exp 5a", rdata); end
        rd(3'd2);
        vecs++; if (rdata !== 8'hFF) begin errs++; $display("FAIL regs_in_ro got %h exp ff", rdata); end
        wr(3'd5, 8'h00);
    endtask

    task automatic test_edge_irq();
        pad_i = 8'h00;
        idle(30);
        wr(3'd3, 8'hFF);
        wr(3'd4, 8'hFF);
        wr(3'd5, 8'h01);
        idle(2);
        vecs++; if (irq !== 1'b0) begin errs++; $display("FAIL edge_irq_idle got %b exp 0", irq); end
        pad_i[0] = 1'b1;
        for (int k = 0; k <= EDGE_LAT; k++) begin
            tick();
            vecs++; if (irq !== (k >= EDGE_LAT)) begin errs++; $display("FAIL edge_irq_lat k=%0d got %b exp %b", k, irq, k >= EDGE_LAT); end
        end
        rd(3'd3);
        vecs++; if (rdata !== 8'h01) begin errs++; $display("FAIL edge_rise got %h exp 01", rdata); end
        wr(3'd3, 8'h01);
        tick();
        vecs++; if (irq !== 1'b0) begin errs++; $display("FAIL edge_irq_clear got %b exp 0", irq); end
    endtask

    task automatic test_set_wins();
        pad_i = 8'h09;
        idle(30);
        wr(3'd3, 8'hFF);
        wr(3'd4, 8'hFF);
        pad_i[3] = 1'b0;
        idle(S + D);
        wr(3'd4, 8'h08);
        rd(3'd4);
        vecs++; if (rdata !== 8'h08) begin errs++; $display("FAIL set_wins got %h exp 08", rdata); end
        wr(3'd4, 8'h08);
        rd(3'd4);
        vecs++; if (rdata !== 8'h00) begin errs++; $display("FAIL w1c_clear got %h exp 00", rdata); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_rd [3] = '{8'h27, 8'h0F, 8'h01};
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1; addr = 3'(i);
            @(posedge clk);
            @(negedge clk);
            vecs++; if (rd_valid !== 1'b1 || rdata !== exp_rd[i]) begin errs++; $display("FAIL b2b a=%0d got v=%b %h exp v=1 %h", i, rd_valid, rdata, exp_rd[i]); end
        end
        rd_en = 1'b0;
        tick();
        vecs++; if (rd_valid !== 1'b0 || rdata !== 8'h01) begin errs++; $display("FAIL b2b_hold got v=%b %h exp v=0 01", rd_valid, rdata); end
        wr_en = 1'b1; rd_en = 1'b1; addr = 3'd0; wdata = 8'h3C;
        tick();
        vecs++; if (rdata !== 8'h27) begin errs++; $display("FAIL rw_same got %h exp 27", rdata); end
        rd(3'd0);
        vecs++; if (rdata !== 8'h3C) begin errs++; $display("FAIL rw_after got %h exp 3c", rdata); end
    endtask

`ifdef RV_IO_MODPORT_DEBOUNCE_EN
    task automatic test_debounce();
        pad_i = 8'h00;
        idle(30);
        wr(3'd3, 8'hFF);
        wr(3'd4, 8'hFF);
        pad_i[1] = 1'b1;
        idle(3);
        pad_i[1] = 1'b0;
        idle(12);
        rd(3'd2);
        vecs++; if (rdata[1] !== 1'b0) begin errs++; $display("FAIL deb_pulse_in got %b exp 0", rdata[1]); end
        rd(3'd3);
        vecs++; if (rdata !== 8'h00) begin errs++; $display("FAIL deb_pulse_rise got %h exp 00", rdata); end
        pad_i[1] = 1'b1;
        idle(10);
        rd(3'd2);
        vecs++; if (rdata[1] !== 1'b1) begin errs++; $display("FAIL deb_level_in got %b exp 1", rdata[1]); end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 149) == 0);
            wr_en = ($urandom_range(0, 2) == 0);
            rd_en = ($urandom_range(0, 1) == 0);
            addr  = 3'($urandom_range(0, 7));
            wdata = 8'($urandom);
            if ($urandom_range(0, 3) == 0) pad_i = pad_i ^ (8'd1 << $urandom_range(0, 7));
            @(posedge clk);
            @(negedge clk);
            vecs++; if (pad_o !== m_out) begin errs++; $display("FAIL rnd_pad_o c=%0d got %h exp %h", c, pad_o, m_out); end
            vecs++; if (pad_t !== m_dir) begin errs++; $display("FAIL rnd_pad_t c=%0d got %h exp %h", c, pad_t, m_dir); end
            vecs++; if (irq !== m_irq) begin errs++; $display("FAIL rnd_irq c=%0d got %b exp %b", c, irq, m_irq); end
            vecs++; if (rd_valid !== m_rv) begin errs++; $display("FAIL rnd_rd_valid c=%0d got %b exp %b", c, rd_valid, m_rv); end
            vecs++; if (rdata !== m_rdata) begin errs++; $display("FAIL rnd_rdata c=%0d got %h exp %h", c, rdata, m_rdata); end
        end
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_registers();
        test_edge_irq();
        test_set_wins();
        test_back_to_back();
`ifdef RV_IO_MODPORT_DEBOUNCE_EN
        test_debounce();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
